// File: rtl/lfsr_prng_stream_pkg.sv
// Shared constants for the LFSR pseudo-random stream: default tap masks,
// FSM state encoding and counter sizing.
package lfsr_prng_stream_pkg;

    // Fibonacci feedback masks, MSB always set (maximal-length polynomials)
    localparam logic [15:0] TAPS_16 = 16'hD008;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;
    localparam logic [63:0] TAPS_64 = 64'h8000_0000_0000_000D;

    typedef logic [0:0] prng_state_t;

    localparam prng_state_t ST_WARMUP = 1'b0;
    localparam prng_state_t ST_RUN    = 1'b1;

    // Width of a counter that must reach max_val; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        if (max_val < 32'd1) begin
            w = 32'd1;
        end else begin
            w = $clog2(max_val + 32'd1);
        end
        return w;
    endfunction

endpackage

// File: rtl/lfsr_prng_stream_if.sv
// Control and output-stream bundle of the LFSR generator; master is the
// generator side, slave the consumer/controller side.
interface lfsr_prng_stream_if #(
    parameter int unsigned LFSR_W = 64,
    parameter int unsigned OUT_W  = 16
);
    logic              en;
    logic              seed_load;
    logic [LFSR_W-1:0] seed;
    logic              rnd_ready;
    logic              rnd_valid;
    logic [OUT_W-1:0]  rnd_data;
    logic              warming;
    logic              seed_zero;

    modport master (
        input  en, seed_load, seed, rnd_ready,
        output rnd_valid, rnd_data, warming, seed_zero
    );

    modport slave (
        output en, seed_load, seed, rnd_ready,
        input  rnd_valid, rnd_data, warming, seed_zero
    );
endinterface

// File: rtl/lfsr_step_core.sv
// LFSR register with seed mux and zero-seed substitution; exposes both the
// current state and the value one shift ahead.
module lfsr_step_core
    import lfsr_prng_stream_pkg::*;
#(
    parameter int unsigned       LFSR_W = 64,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_64),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(64'd1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [LFSR_W-1:0] lfsr_o,
    output logic [LFSR_W-1:0] lfsr_next_o,
    output logic              seed_zero_o
);
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic              fb_s;

    assign fb_s        = ^(lfsr_q & TAPS);
    assign lfsr_next_o = {lfsr_q[LFSR_W-2:0], fb_s};
    assign seed_zero_o = (seed_i == {LFSR_W{1'b0}});
    assign lfsr_o      = lfsr_q;

    // Load beats step; an all-zero seed would lock the LFSR, so SEED stands in
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            if (seed_zero_o) begin
                lfsr_d = SEED;
            end else begin
                lfsr_d = seed_i;
            end
        end else if (step_i) begin
            lfsr_d = lfsr_next_o;
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
endmodule

// File: rtl/lfsr_prng_stream.sv
// Parametrised Fibonacci-LFSR generator: warm-up discard, then one word per
// STEPS_PER_OUT shifts into a single valid/ready output slot.
module lfsr_prng_stream
    import lfsr_prng_stream_pkg::*;
#(
    parameter int unsigned       LFSR_W        = 64,
    parameter logic [LFSR_W-1:0] TAPS          = LFSR_W'(TAPS_64),
    parameter logic [LFSR_W-1:0] SEED          = LFSR_W'(64'd1),
    parameter int unsigned       OUT_W         = 16,
    parameter int unsigned       STEPS_PER_OUT = 16,
    parameter int unsigned       WARMUP_STEPS  = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lfsr_prng_stream_if.master   prng_bus
);
    if (LFSR_W < 32'd8) begin : g_err_width
        $error("LFSR_W must be at least 8");
    end
    if (TAPS[LFSR_W-1] == 1'b0) begin : g_err_taps
        $error("TAPS must set bit LFSR_W-1");
    end
    if (SEED == {LFSR_W{1'b0}}) begin : g_err_seed
        $error("SEED must be non-zero");
    end
    if ((OUT_W > LFSR_W) || (OUT_W < 32'd1)) begin : g_err_out_w
        $error("OUT_W must be in 1..LFSR_W");
    end
    if (STEPS_PER_OUT == 32'd0) begin : g_err_steps
        $error("STEPS_PER_OUT must be at least 1");
    end

    localparam int unsigned STEP_MAX = (STEPS_PER_OUT > 32'd0) ? STEPS_PER_OUT - 32'd1 : 32'd0;
    localparam int unsigned WARM_MAX = (WARMUP_STEPS > 32'd0) ? WARMUP_STEPS - 32'd1 : 32'd0;
    localparam int unsigned STEP_CW  = cnt_width(STEP_MAX);
    localparam int unsigned WARM_CW  = cnt_width(WARM_MAX);
    localparam logic [STEP_CW-1:0] STEP_LAST = STEP_CW'(STEP_MAX);
    localparam logic [WARM_CW-1:0] WARM_LAST = WARM_CW'(WARM_MAX);
    localparam prng_state_t        ST_INIT   = (WARMUP_STEPS == 32'd0) ? ST_RUN : ST_WARMUP;

    prng_state_t        state_q, state_d;
    logic [WARM_CW-1:0] warm_cnt_q, warm_cnt_d;
    logic [STEP_CW-1:0] step_cnt_q, step_cnt_d;
    logic               rnd_valid_q, rnd_valid_d;
    logic [OUT_W-1:0]   rnd_data_q, rnd_data_d;
    logic               seed_zero_q, seed_zero_d;

    logic               step_s;
    logic               last_s;
    logic               slot_free_s;
    logic               seed_is_zero_s;
    logic [LFSR_W-1:0]  lfsr_next_s;
    logic [LFSR_W-1:0]  lfsr_cur_unused_s;

    lfsr_step_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .step_i      (step_s),
        .load_i      (prng_bus.seed_load),
        .seed_i      (prng_bus.seed),
        .lfsr_o      (lfsr_cur_unused_s),
        .lfsr_next_o (lfsr_next_s),
        .seed_zero_o (seed_is_zero_s)
    );

    assign last_s      = (step_cnt_q == STEP_LAST);
    assign slot_free_s = !rnd_valid_q || prng_bus.rnd_ready;

    // Only the word-producing shift waits for the slot; all others run freely
    always_comb begin
        step_s = 1'b0;
        case (state_q)
            ST_WARMUP: step_s = prng_bus.en;
            ST_RUN:    step_s = prng_bus.en && (!last_s || slot_free_s);
            default:   step_s = 1'b0;
        endcase
    end

    // FSM, counters and output slot; a consume and a new word on one edge leave valid high
    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        step_cnt_d  = step_cnt_q;
        rnd_valid_d = rnd_valid_q;
        rnd_data_d  = rnd_data_q;
        seed_zero_d = 1'b0;
        if (prng_bus.seed_load) begin
            state_d     = ST_INIT;
            warm_cnt_d  = {WARM_CW{1'b0}};
            step_cnt_d  = {STEP_CW{1'b0}};
            rnd_valid_d = 1'b0;
            seed_zero_d = seed_is_zero_s;
        end else begin
            if (rnd_valid_q && prng_bus.rnd_ready) begin
                rnd_valid_d = 1'b0;
            end else begin
                rnd_valid_d = rnd_valid_q;
            end
            case (state_q)
                ST_WARMUP: begin
                    if (step_s && (warm_cnt_q == WARM_LAST)) begin
                        state_d    = ST_RUN;
                        warm_cnt_d = {WARM_CW{1'b0}};
                    end else if (step_s) begin
                        warm_cnt_d = warm_cnt_q + WARM_CW'(1'b1);
                    end else begin
                        warm_cnt_d = warm_cnt_q;
                    end
                end
                ST_RUN: begin
                    if (step_s && last_s) begin
                        rnd_data_d  = lfsr_next_s[OUT_W-1:0];
                        rnd_valid_d = 1'b1;
                        step_cnt_d  = {STEP_CW{1'b0}};
                    end else if (step_s) begin
                        step_cnt_d = step_cnt_q + STEP_CW'(1'b1);
                    end else begin
                        step_cnt_d = step_cnt_q;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            warm_cnt_q  <= {WARM_CW{1'b0}};
            step_cnt_q  <= {STEP_CW{1'b0}};
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= {OUT_W{1'b0}};
            seed_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            step_cnt_q  <= step_cnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            seed_zero_q <= seed_zero_d;
        end
    end

    assign prng_bus.rnd_valid = rnd_valid_q;
    assign prng_bus.rnd_data  = rnd_data_q;
    assign prng_bus.seed_zero = seed_zero_q;
    assign prng_bus.warming   = (state_q == ST_WARMUP);
endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Directed bench for lfsr_prng_stream: three instances (1 and 4 steps per word
// without warm-up, and the default configuration) share clock and reset.
module tb_lfsr_prng_stream;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lfsr_prng_stream_if #(.LFSR_W(64), .OUT_W(16)) bus1 ();
    lfsr_prng_stream_if #(.LFSR_W(64), .OUT_W(16)) bus2 ();
    lfsr_prng_stream_if #(.LFSR_W(64), .OUT_W(16)) bus3 ();

    lfsr_prng_stream #(.STEPS_PER_OUT(1), .WARMUP_STEPS(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .prng_bus(bus1));
    lfsr_prng_stream #(.STEPS_PER_OUT(4), .WARMUP_STEPS(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .prng_bus(bus2));
    lfsr_prng_stream u_dut3 (
        .clk(clk), .rst_n(rst_n), .prng_bus(bus3));

    // Independent model of x^64+x^4+x^3+x+1 written out bit by bit
    function automatic logic [63:0] ref_lfsr(input logic [63:0] start, input int n);
        logic [63:0] x;
        x = start;
        for (int i = 0; i < n; i++) begin
            x = {x[62:0], x[63] ^ x[3] ^ x[2] ^ x[0]};
        end
        return x;
    endfunction

    function automatic logic [15:0] ref_word(input logic [63:0] start, input int n);
        logic [63:0] x;
        x = ref_lfsr(start, n);
        return x[15:0];
    endfunction

    task automatic idle_all();
        bus1.en = 1'b0; bus1.seed_load = 1'b0; bus1.seed = 64'd0; bus1.rnd_ready = 1'b0;
        bus2.en = 1'b0; bus2.seed_load = 1'b0; bus2.seed = 64'd0; bus2.rnd_ready = 1'b0;
        bus3.en = 1'b0; bus3.seed_load = 1'b0; bus3.seed = 64'd0; bus3.rnd_ready = 1'b0;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_u3(input string name, input logic want_v, input logic [15:0] want_d);
        checks++;
        if ({bus3.rnd_valid, bus3.rnd_data} !== {want_v, want_d}) begin
            errors++;
            $display("FAIL %s: got valid=%0b data=%h, want valid=%0b data=%h",
                     name, bus3.rnd_valid, bus3.rnd_data, want_v, want_d);
        end
    endtask

    task automatic test_reset();
        hold_reset();
        checks++;
        if ({bus3.rnd_valid, bus3.rnd_data, bus3.warming, bus3.seed_zero} !== {1'b0, 16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut3: got v=%0b d=%h warm=%0b sz=%0b, want v=0 d=0000 warm=1 sz=0",
                     bus3.rnd_valid, bus3.rnd_data, bus3.warming, bus3.seed_zero);
        end
        checks++;
        if ({bus1.rnd_valid, bus1.rnd_data, bus1.warming, bus1.seed_zero} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut1: got v=%0b d=%h warm=%0b sz=%0b, want v=0 d=0000 warm=0 sz=0",
                     bus1.rnd_valid, bus1.rnd_data, bus1.warming, bus1.seed_zero);
        end
    endtask

    task automatic test_step1();
        logic [15:0] exp_w [4];
        exp_w[0] = 16'h0003; exp_w[1] = 16'h0007; exp_w[2] = 16'h000E; exp_w[3] = 16'h001C;
        hold_reset();
        bus1.en = 1'b1; bus1.rnd_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({bus1.rnd_valid, bus1.rnd_data} !== {1'b1, exp_w[k]}) begin
                errors++;
                $display("FAIL step1_edge%0d: got valid=%0b data=%h, want valid=1 data=%h",
                         k + 1, bus1.rnd_valid, bus1.rnd_data, exp_w[k]);
            end
        end
    endtask

    task automatic test_step4();
        logic [16:0] exp_s [8];
        exp_s[0] = {1'b0, 16'h0000}; exp_s[1] = {1'b0, 16'h0000}; exp_s[2] = {1'b0, 16'h0000};
        exp_s[3] = {1'b1, 16'h001C}; exp_s[4] = {1'b0, 16'h001C}; exp_s[5] = {1'b0, 16'h001C};
        exp_s[6] = {1'b0, 16'h001C}; exp_s[7] = {1'b1, 16'h01C7};
        hold_reset();
        bus2.en = 1'b1; bus2.rnd_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({bus2.rnd_valid, bus2.rnd_data} !== exp_s[k]) begin
                errors++;
                $display("FAIL step4_edge%0d: got valid=%0b data=%h, want valid=%0b data=%h",
                         k + 1, bus2.rnd_valid, bus2.rnd_data, exp_s[k][16], exp_s[k][15:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        hold_reset();
        bus3.en = 1'b1; bus3.rnd_ready = 1'b0;
        rst_n = 1'b1;
        repeat (79) @(negedge clk);
        check_u3("bp_latency_edge79", 1'b0, 16'h0000);
        @(negedge clk);
        check_u3("bp_first_word_edge80", 1'b1, ref_word(64'd1, 80));
        repeat (30) @(negedge clk);
        check_u3("bp_stall_hold_edge110", 1'b1, ref_word(64'd1, 80));
        bus3.rnd_ready = 1'b1;
        @(negedge clk);
        check_u3("bp_consume_and_load_edge111", 1'b1, ref_word(64'd1, 96));
        bus3.rnd_ready = 1'b0;
        repeat (29) @(negedge clk);
        check_u3("bp_second_stall_edge140", 1'b1, ref_word(64'd1, 96));
        bus3.rnd_ready = 1'b1;
        @(negedge clk);
        check_u3("bp_third_word_edge141", 1'b1, ref_word(64'd1, 112));
        @(negedge clk);
        checks++;
        if (bus3.rnd_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_consume_clears: got valid=%0b, want valid=0", bus3.rnd_valid);
        end
    endtask

    task automatic test_seed_load();
        hold_reset();
        bus3.en = 1'b1; bus3.rnd_ready = 1'b0;
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        bus3.seed_load = 1'b1; bus3.seed = 64'd0;
        @(negedge clk);
        checks++;
        if ({bus3.seed_zero, bus3.rnd_valid, bus3.warming} !== 3'b101) begin
            errors++;
            $display("FAIL seed_zero_load: got sz=%0b valid=%0b warm=%0b, want sz=1 valid=0 warm=1",
                     bus3.seed_zero, bus3.rnd_valid, bus3.warming);
        end
        bus3.seed_load = 1'b0; bus3.rnd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus3.seed_zero !== 1'b0) begin
            errors++;
            $display("FAIL seed_zero_pulse_width: got sz=%0b, want sz=0", bus3.seed_zero);
        end
        repeat (62) @(negedge clk);
        checks++;
        if (bus3.warming !== 1'b1) begin
            errors++;
            $display("FAIL seed_warm_last_cycle: got warming=%0b, want warming=1", bus3.warming);
        end
        @(negedge clk);
        checks++;
        if (bus3.warming !== 1'b0) begin
            errors++;
            $display("FAIL seed_warm_exit: got warming=%0b, want warming=0", bus3.warming);
        end
        repeat (15) @(negedge clk);
        check_u3("seed_before_first_word", 1'b0, ref_word(64'd1, 80));
        @(negedge clk);
        check_u3("seed_zero_first_word", 1'b1, ref_word(64'd1, 80));
        repeat (16) @(negedge clk);
        check_u3("seed_zero_second_word", 1'b1, ref_word(64'd1, 96));
        // Non-zero seed loaded while en is low: load still happens
        bus3.en = 1'b0; bus3.seed_load = 1'b1; bus3.seed = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({bus3.seed_zero, bus3.rnd_valid, bus3.warming} !== 3'b001) begin
            errors++;
            $display("FAIL seed_value_load: got sz=%0b valid=%0b warm=%0b, want sz=0 valid=0 warm=1",
                     bus3.seed_zero, bus3.rnd_valid, bus3.warming);
        end
        bus3.en = 1'b1; bus3.seed_load = 1'b0; bus3.seed = 64'd0;
        repeat (80) @(negedge clk);
        check_u3("seed_value_first_word", 1'b1, ref_word(64'h0000_0000_DEAD_BEEF, 80));
    endtask

    task automatic test_en_toggle();
        hold_reset();
        bus3.en = 1'b1; bus3.rnd_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 191; k++) begin
            @(negedge clk);
            if (k == 158) check_u3("en_toggle_edge158", 1'b0, 16'h0000);
            if (k == 159) check_u3("en_toggle_first_word", 1'b1, ref_word(64'd1, 80));
            if (k == 160) begin
                checks++;
                if (bus3.rnd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL en_low_consume: got valid=%0b, want valid=0", bus3.rnd_valid);
                end
            end
            if (k == 191) check_u3("en_toggle_second_word", 1'b1, ref_word(64'd1, 96));
            bus3.en = ((k + 1) % 2 == 1);
        end
    endtask

    task automatic test_reset_mid();
        hold_reset();
        bus3.en = 1'b1; bus3.rnd_ready = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus3.rnd_valid, bus3.rnd_data, bus3.warming} !== {1'b0, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid_warmup: got v=%0b d=%h warm=%0b, want v=0 d=0000 warm=1",
                     bus3.rnd_valid, bus3.rnd_data, bus3.warming);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check_u3("rst_restart_word", 1'b1, ref_word(64'd1, 80));
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus3.rnd_valid, bus3.rnd_data, bus3.warming} !== {1'b0, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL rst_while_stalled: got v=%0b d=%h warm=%0b, want v=0 d=0000 warm=1",
                     bus3.rnd_valid, bus3.rnd_data, bus3.warming);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus3.seed_load = 1'b1; bus3.seed = 64'd0;
        @(negedge clk);
        bus3.seed_load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus3.seed_zero !== 1'b0) begin
            errors++;
            $display("FAIL rst_clears_seed_zero: got sz=%0b, want sz=0", bus3.seed_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        test_reset();
        test_step1();
        test_step4();
        test_backpressure();
        test_seed_load();
        test_en_toggle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
